// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder.
// Computes {cout, sum} = A + B + cin through a chain of one-bit full-adder
// cells and captures the result every rising clock edge. The outputs come
// straight from flops so that board-level consumers (LEDs) see clean,
// clock-aligned values. An asynchronous active-low reset clears the flops.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One full-adder cell: returns {carry_out, sum_bit}.
  // The carry is the majority of the three inputs.
  function automatic logic [1:0] fa_cell(
    input logic a,
    input logic b,
    input logic c
  );
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Combinational ripple chain, LSB to MSB, with cin feeding bit 0.
  // The running carry is a block-local variable, so the chain has no
  // feedback through a shared vector.
  always_comb begin
    logic       v_carry;
    logic [1:0] v_cell;
    w_sum   = '0;
    v_carry = cin;
    v_cell  = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      v_cell   = fa_cell(A[i], B[i], v_carry);
      w_sum[i] = v_cell[0];
      v_carry  = v_cell[1];
    end
    w_cout = v_carry;
  end

  // Output registers: capture the new result every cycle; reset clears
  // them immediately, independent of the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: self-checking bench for full_adder at WIDTH = 1, 4 and 8.
// Expected results are computed with plain integer addition of the applied
// operands; every comparison goes through check_eq.
`timescale 1ns/1ps
module tb_full_adder;

  logic       clk;
  logic       reset_n;

  logic [0:0] a1, b1;
  logic       c1;
  logic [0:0] s1;
  logic       co1;

  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] s4;
  logic       co4;

  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8;
  logic       co8;

  int n_checks;
  int n_fail;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .A(a1), .B(b1), .cin(c1), .sum(s1), .cout(co1)
  );
  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .A(a4), .B(b4), .cin(c4), .sum(s4), .cout(co4)
  );
  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .A(a8), .B(b8), .cin(c8), .sum(s8), .cout(co8)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one vector to the WIDTH=1 adder at the falling edge and check
  // the registered result just after the next rising edge.
  task automatic apply1(input string tag, input int a, input int b, input int c);
    @(negedge clk);
    a1 = a[0:0];
    b1 = b[0:0];
    c1 = c[0];
    @(posedge clk);
    #1;
    check_eq(tag, 32'({co1, s1}), 32'(a + b + c));
  endtask

  task automatic apply4(input string tag, input int a, input int b, input int c);
    @(negedge clk);
    a4 = a[3:0];
    b4 = b[3:0];
    c4 = c[0];
    @(posedge clk);
    #1;
    check_eq(tag, 32'({co4, s4}), 32'(a + b + c));
  endtask

  initial begin
    int ra, rb, rc;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; c8 = 1'b0;

    // Reset holds outputs at zero while the clock runs and inputs are all ones.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold_w1_pos", 32'({co1, s1}), 32'd0);
      @(negedge clk);
      check_eq("rst_hold_w1_neg", 32'({co1, s1}), 32'd0);
    end
    check_eq("rst_w4", 32'({co4, s4}), 32'd0);
    check_eq("rst_w8", 32'({co8, s8}), 32'd0);

    // Release between edges: the very next edge captures 1+1+1.
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_release", 32'({co1, s1}), 32'd3);

    // Exhaustive WIDTH=1 truth table, {A,B,cin} from 000 to 111.
    for (int v = 0; v < 8; v++) begin
      apply1($sformatf("truth_%0d%0d%0d", (v >> 2) & 1, (v >> 1) & 1, v & 1),
             (v >> 2) & 1, (v >> 1) & 1, v & 1);
    end

    // Back-to-back: 001, 110, 111; also confirm each result holds to the
    // following falling edge.
    apply1("tput_001", 0, 0, 1);
    @(negedge clk);
    check_eq("tput_hold_001", 32'({co1, s1}), 32'd1);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tput_110", 32'({co1, s1}), 32'd2);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("tput_111", 32'({co1, s1}), 32'd3);

    // Asynchronous reset pulse between edges.
    apply1("async_pre", 1, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_clear", 32'({co1, s1}), 32'd0);
    #1;
    reset_n = 1'b1;
    #1;
    check_eq("async_still0", 32'({co1, s1}), 32'd0);
    @(posedge clk);
    #1;
    check_eq("async_recover", 32'({co1, s1}), 32'd2);

    // WIDTH=4 wrap-around corners.
    apply4("wrap_f_1_0", 15, 1, 0);
    apply4("wrap_f_f_1", 15, 15, 1);
    apply4("wrap_5_2_1", 5, 2, 1);
    apply4("wrap_0_0_0", 0, 0, 0);

    // WIDTH=8 random regression, one new vector every cycle.
    for (int k = 0; k < 1000; k++) begin
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      rc = int'($urandom_range(1, 0));
      if (k == 0) begin
        ra = 255; rb = 255; rc = 1;
      end else begin
        ra = ra;
      end
      @(negedge clk);
      a8 = ra[7:0];
      b8 = rb[7:0];
      c8 = rc[0];
      @(posedge clk);
      #1;
      check_eq($sformatf("rand8_%0d", k), 32'({co8, s8}), 32'(ra + rb + rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
